// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: fetches one cache block from main memory as a burst of
// pipelined word reads and streams the returned words into the cache data/tag arrays.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_W-1:0]                  memory_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_offset,
  output logic [15:0]                        fill_data
);

  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W   = OFF_W + 1;
  // Block is WORDS_PER_BLOCK 16-bit words, so the byte offset spans OFF_W+1 bits.
  localparam int BLK_LSB = OFF_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [ADDR_W-1:0] base;
  logic              req_active;
  logic              rcv_fire;

  assign req_active = (state == FILL) && (req_cnt < FULL);
  assign rcv_fire   = (state == FILL) && memory_data_valid && (rcv_cnt < FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_cnt <= '0;
      rcv_cnt <= '0;
      base    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= {miss_address[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (req_active) req_cnt <= req_cnt + 1'b1;
          if (rcv_fire) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the miss cycle itself, hence the combinational IDLE term.
  assign fsm_busy         = (state == FILL) || (rst_n && (state == IDLE) && miss_detected);
  assign memory_read      = req_active;
  assign memory_address   = req_active ? (base + (ADDR_W'(req_cnt) << 1)) : '0;
  assign write_data_array = rcv_fire;
  assign write_tag_array  = rcv_fire && (rcv_cnt == LAST);
  assign fill_offset      = rcv_fire ? rcv_cnt[OFF_W-1:0] : '0;
  assign fill_data        = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a latency/gap-configurable memory responder and
// queue scoreboards for read requests and array writes.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  fill_offset;
  logic [15:0] fill_data;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_offset       (fill_offset),
    .fill_data         (fill_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  logic [15:0] exp_addr[$];
  wr_t         exp_wr[$];
  ret_t        mem_q[$];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int mem_lat = 4;
  int mem_gap = 0;
  int next_ok = 0;
  logic spur_valid = 1'b0;

  int busy_n, req_n, wr_n, tag_n;
  int first_req, last_req, first_wr, last_wr;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_n = 0; req_n = 0; wr_n = 0; tag_n = 0;
    first_req = -1; last_req = -1; first_wr = -1; last_wr = -1;
  endtask

  task automatic push_fill(input logic [15:0] a);
    logic [15:0] b;
    wr_t e;
    b = a & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_addr.push_back(b + 16'(2 * k));
      e.off  = 3'(k);
      e.data = mdata(b + 16'(2 * k));
      e.tag  = (k == 7);
      exp_wr.push_back(e);
    end
  endtask

  task automatic monitor();
    ret_t r;
    wr_t  e;
    if (fsm_busy) busy_n++;
    if (memory_read) begin
      req_n++;
      if (first_req < 0) first_req = cycle;
      last_req = cycle;
      if (exp_addr.size() == 0) chk("unexpected_read", 32'(memory_address), 32'hFFFF_FFFF);
      else chk("read_addr", 32'(memory_address), 32'(exp_addr.pop_front()));
      r.due  = cycle + mem_lat;
      r.data = mdata(memory_address);
      mem_q.push_back(r);
    end
    if (write_data_array) begin
      wr_n++;
      if (first_wr < 0) first_wr = cycle;
      last_wr = cycle;
      if (write_tag_array) tag_n++;
      chk("write_needs_valid", 32'(memory_data_valid), 32'd1);
      if (exp_wr.size() == 0) chk("unexpected_write", 32'(fill_offset), 32'hFFFF_FFFF);
      else begin
        e = exp_wr.pop_front();
        chk("fill_offset", 32'(fill_offset), 32'(e.off));
        chk("fill_data", 32'(fill_data), 32'(e.data));
        chk("tag_write", 32'(write_tag_array), 32'(e.tag));
      end
    end else if (write_tag_array) begin
      tag_n++;
      chk("tag_without_write", 32'(write_tag_array), 32'd0);
    end
  endtask

  task automatic mem_drive();
    if (mem_q.size() > 0 && mem_q[0].due <= cycle && cycle >= next_ok) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_q[0].data;
      void'(mem_q.pop_front());
      next_ok = cycle + 1 + mem_gap;
    end else begin
      memory_data_valid = spur_valid;
      memory_data       = 16'($urandom());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cycle++;
    mem_drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic start_miss(input logic [15:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    push_fill(a);
    cyc();
    miss_detected = 1'b0;
    miss_address  = 16'($urandom());
  endtask

  int m;

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    clear_stats();

    // Reset state, including a miss and a memory word arriving while held in reset
    #12;
    chk("rst_busy", 32'(fsm_busy), 32'd0);
    chk("rst_read", 32'(memory_read), 32'd0);
    chk("rst_addr", 32'(memory_address), 32'd0);
    miss_detected = 1'b1; miss_address = 16'h1234;
    memory_data_valid = 1'b1; memory_data = 16'hBEEF;
    #1;
    chk("rst_busy_miss", 32'(fsm_busy), 32'd0);
    chk("rst_wda", 32'(write_data_array), 32'd0);
    chk("rst_wta", 32'(write_tag_array), 32'd0);
    chk("rst_offset", 32'(fill_offset), 32'd0);
    chk("rst_fill_data", 32'(fill_data), 32'hBEEF);
    miss_detected = 1'b0; memory_data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle = 0;

    // Test 1: miss at 0x1236, 4-cycle memory
    clear_stats();
    m = cycle;
    miss_detected = 1'b1; miss_address = 16'h1236;
    #1;
    chk("t1_busy_miss_cycle", 32'(fsm_busy), 32'd1);
    push_fill(16'h1236);
    cyc();
    miss_detected = 1'b0;
    run(16);
    chk("t1_busy_cycles", 32'(busy_n), 32'd13);
    chk("t1_req_n", 32'(req_n), 32'd8);
    chk("t1_first_req", 32'(first_req), 32'(m + 1));
    chk("t1_last_req", 32'(last_req), 32'(m + 8));
    chk("t1_first_wr", 32'(first_wr), 32'(m + 5));
    chk("t1_last_wr", 32'(last_wr), 32'(m + 12));
    chk("t1_wr_n", 32'(wr_n), 32'd8);
    chk("t1_tag_n", 32'(tag_n), 32'd1);
    chk("t1_idle", 32'(fsm_busy), 32'd0);

    // Test 2: returns separated by 2 idle cycles
    clear_stats();
    mem_gap = 2;
    start_miss(16'h2468);
    run(30);
    chk("t2_busy_cycles", 32'(busy_n), 32'd27);
    chk("t2_wr_n", 32'(wr_n), 32'd8);
    chk("t2_tag_n", 32'(tag_n), 32'd1);
    chk("t2_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    mem_gap = 0;

    // Test 3: second miss mid-fill is ignored
    clear_stats();
    start_miss(16'h123A);
    run(2);
    miss_detected = 1'b1; miss_address = 16'h4000;
    cyc();
    miss_detected = 1'b0;
    run(14);
    chk("t3_busy_cycles", 32'(busy_n), 32'd13);
    chk("t3_req_n", 32'(req_n), 32'd8);
    chk("t3_addr_queue_empty", 32'(exp_addr.size()), 32'd0);

    // Test 4: reset during FILL cycle 6, then a clean refill
    clear_stats();
    start_miss(16'h3000);
    run(6);
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(fsm_busy), 32'd0);
    chk("t4_read", 32'(memory_read), 32'd0);
    chk("t4_addr", 32'(memory_address), 32'd0);
    chk("t4_wda", 32'(write_data_array), 32'd0);
    chk("t4_wta", 32'(write_tag_array), 32'd0);
    chk("t4_offset", 32'(fill_offset), 32'd0);
    exp_addr.delete(); exp_wr.delete(); mem_q.delete();
    run(2);
    rst_n = 1'b1;
    chk("t4_no_tag_in_abort", 32'(tag_n), 32'd0);
    clear_stats();
    start_miss(16'h3010);
    run(16);
    chk("t4_refill_wr_n", 32'(wr_n), 32'd8);
    chk("t4_refill_tag_n", 32'(tag_n), 32'd1);
    chk("t4_refill_busy", 32'(busy_n), 32'd13);

    // Test 5: top block, no address wrap
    clear_stats();
    start_miss(16'hFFFF);
    run(16);
    chk("t5_req_n", 32'(req_n), 32'd8);
    chk("t5_wr_n", 32'(wr_n), 32'd8);
    chk("t5_addr_queue_empty", 32'(exp_addr.size()), 32'd0);

    // Test 6: spurious valid while idle
    clear_stats();
    spur_valid = 1'b1;
    run(4);
    #1;
    chk("t6_busy_now", 32'(fsm_busy), 32'd0);
    spur_valid = 1'b0;
    cyc();
    chk("t6_busy_cycles", 32'(busy_n), 32'd0);
    chk("t6_wr_n", 32'(wr_n), 32'd0);
    chk("t6_tag_n", 32'(tag_n), 32'd0);

    // Test 7: back-to-back miss in the cycle after the tag write
    clear_stats();
    start_miss(16'h5000);
    run(12);
    start_miss(16'h6002);
    run(16);
    chk("t7_busy_cycles", 32'(busy_n), 32'd26);
    chk("t7_wr_n", 32'(wr_n), 32'd16);
    chk("t7_tag_n", 32'(tag_n), 32'd2);
    chk("t7_wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
